// File: rtl/sisc_exec_if.sv
// sisc_exec_if: bundle between the SISC execute core and its neighbours
// (instruction register, register file, status register, memory read port).
//   instruction : 32-bit instruction word ([31:28] opcode, [27:24] mm, [15:0] imm, [3:0] funct)
//   rsa, rsb    : register operands A and B
//   mem_data    : memory read data, write-back source for loads
//   stat_in     : current {C,V,N,Z} from the status register
//   alu_result  : ALU result
//   stat_out    : new {C,V,N,Z} from the ALU
//   stat_en     : status-register load enable
//   write_data  : register-file write data
//   rf_we       : register-file write enable
//   wb_sel      : write-back source, 0 = ALU result, 1 = mem_data
//   alu_op      : [0] immediate operand select, [1] address mode (rsa + imm)
//   halted      : HLT has been executed
// Modport master is the core side; slave is the surrounding datapath side.
interface sisc_exec_if #(
    parameter int WIDTH = 32
);
    logic [31:0]      instruction;
    logic [WIDTH-1:0] rsa;
    logic [WIDTH-1:0] rsb;
    logic [WIDTH-1:0] mem_data;
    logic [3:0]       stat_in;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       stat_out;
    logic             stat_en;
    logic [WIDTH-1:0] write_data;
    logic             rf_we;
    logic             wb_sel;
    logic [1:0]       alu_op;
    logic             halted;

    modport master (
        input  instruction, rsa, rsb, mem_data, stat_in,
        output alu_result, stat_out, stat_en, write_data, rf_we, wb_sel, alu_op, halted
    );

    modport slave (
        output instruction, rsa, rsb, mem_data, stat_in,
        input  alu_result, stat_out, stat_en, write_data, rf_we, wb_sel, alu_op, halted
    );
endinterface

// File: rtl/sisc_exec_core.sv
// sisc_exec_core: execute/control slice of the SISC multicycle processor.
// Holds the control FSM, the combinational ALU and the write-back mux.
// Only the FSM state is registered; every output is decoded from the state
// and the (externally held) instruction, so an asynchronous reset drops all
// enables in the same instant.
//   clk   : clock, all state on the rising edge
//   rst_f : asynchronous active-low reset
//   bus   : sisc_exec_if.master (operands, instruction, status, enables)
module sisc_exec_core #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_f,
    sisc_exec_if.master   bus
);

    localparam logic [3:0] OPC_LOD = 4'd1;
    localparam logic [3:0] OPC_STR = 4'd2;
    localparam logic [3:0] OPC_ALU = 4'd8;
    localparam logic [3:0] OPC_HLT = 4'd15;

    typedef enum logic [2:0] {
        START0    = 3'd0,
        START1    = 3'd1,
        FETCH     = 3'd2,
        DECODE    = 3'd3,
        EXECUTE   = 3'd4,
        MEM       = 3'd5,
        WRITEBACK = 3'd6,
        HALT      = 3'd7
    } state_t;

    state_t state_r;
    state_t next_state_s;

    logic [3:0]       opcode_s;
    logic             mm_imm_s;
    logic [15:0]      imm_s;
    logic [3:0]       funct_s;
    logic             is_alu_s;
    logic             is_lod_s;
    logic             is_mem_s;
    logic [1:0]       dec_alu_op_s;

    logic             stat_en_s;
    logic             rf_we_s;
    logic             wb_sel_s;
    logic [1:0]       alu_op_s;
    logic             halted_s;

    logic [WIDTH-1:0] imm_sext_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH:0]   wide_s;
    logic [WIDTH-1:0] result_s;
    logic             carry_s;
    logic             ovf_s;
    logic [3:0]       stat_s;
    logic             unused_s;

    assign opcode_s   = bus.instruction[31:28];
    assign mm_imm_s   = bus.instruction[27];
    assign imm_s      = bus.instruction[15:0];
    assign funct_s    = bus.instruction[3:0];
    assign is_alu_s   = (opcode_s == OPC_ALU);
    assign is_lod_s   = (opcode_s == OPC_LOD);
    assign is_mem_s   = is_lod_s || (opcode_s == OPC_STR);
    assign imm_sext_s = {{(WIDTH-16){imm_s[15]}}, imm_s};

    // Status input is reserved for branches; instruction bits [26:16] are not decoded here.
    assign unused_s = ^{bus.stat_in, bus.instruction[26:16]};

    // ALU operating mode for this instruction while it is in EXECUTE..WRITEBACK.
    always_comb begin
        if (is_alu_s && mm_imm_s) begin
            dec_alu_op_s = 2'b01;
        end else if (is_mem_s) begin
            dec_alu_op_s = 2'b10;
        end else begin
            dec_alu_op_s = 2'b00;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_r <= START0;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state and per-state control outputs.
    always_comb begin
        next_state_s = state_r;
        stat_en_s    = 1'b0;
        rf_we_s      = 1'b0;
        wb_sel_s     = 1'b0;
        alu_op_s     = 2'b00;
        halted_s     = 1'b0;
        case (state_r)
            START0:    next_state_s = START1;
            START1:    next_state_s = FETCH;
            FETCH:     next_state_s = DECODE;
            DECODE: begin
                if (opcode_s == OPC_HLT) begin
                    next_state_s = HALT;
                end else begin
                    next_state_s = EXECUTE;
                end
            end
            EXECUTE: begin
                next_state_s = MEM;
                alu_op_s     = dec_alu_op_s;
                stat_en_s    = is_alu_s;
            end
            MEM: begin
                next_state_s = WRITEBACK;
                alu_op_s     = dec_alu_op_s;
            end
            WRITEBACK: begin
                next_state_s = FETCH;
                alu_op_s     = dec_alu_op_s;
                rf_we_s      = is_alu_s || is_lod_s;
                wb_sel_s     = is_lod_s;
            end
            HALT: begin
                next_state_s = HALT;
                halted_s     = 1'b1;
            end
            default:   next_state_s = START0;
        endcase
    end

    assign b_s = alu_op_s[0] ? imm_sext_s : bus.rsb;

    // ALU: result and carry/overflow; the extra top bit of wide_s is carry (ADD) or borrow (SUB).
    always_comb begin
        wide_s   = {(WIDTH+1){1'b0}};
        result_s = {WIDTH{1'b0}};
        carry_s  = 1'b0;
        ovf_s    = 1'b0;
        if (alu_op_s[1]) begin
            result_s = bus.rsa + imm_sext_s;
        end else begin
            case (funct_s)
                4'd1: begin
                    wide_s   = {1'b0, bus.rsa} + {1'b0, b_s};
                    result_s = wide_s[WIDTH-1:0];
                    carry_s  = wide_s[WIDTH];
                    ovf_s    = (bus.rsa[WIDTH-1] == b_s[WIDTH-1]) &&
                               (result_s[WIDTH-1] != bus.rsa[WIDTH-1]);
                end
                4'd2: begin
                    wide_s   = {1'b0, bus.rsa} - {1'b0, b_s};
                    result_s = wide_s[WIDTH-1:0];
                    carry_s  = wide_s[WIDTH];
                    ovf_s    = (bus.rsa[WIDTH-1] != b_s[WIDTH-1]) &&
                               (result_s[WIDTH-1] != bus.rsa[WIDTH-1]);
                end
                4'd3:    result_s = ~bus.rsa;
                4'd4:    result_s = bus.rsa | b_s;
                4'd5:    result_s = bus.rsa & b_s;
                4'd6:    result_s = bus.rsa ^ b_s;
                4'd7:    result_s = bus.rsa << b_s[4:0];
                4'd8:    result_s = bus.rsa >> b_s[4:0];
                default: result_s = {WIDTH{1'b0}};
            endcase
        end
    end

    // Address mode produces no status; otherwise {C,V,N,Z}.
    assign stat_s = alu_op_s[1] ? 4'b0000
                  : {carry_s, ovf_s, result_s[WIDTH-1], (result_s == {WIDTH{1'b0}})};

    assign bus.alu_result = result_s;
    assign bus.stat_out   = stat_s;
    assign bus.stat_en    = stat_en_s;
    assign bus.rf_we      = rf_we_s;
    assign bus.wb_sel     = wb_sel_s;
    assign bus.alu_op     = alu_op_s;
    assign bus.halted     = halted_s;
    assign bus.write_data = wb_sel_s ? bus.mem_data : result_s;

endmodule

// File: tb/tb_sisc_exec_core.sv
// Self-checking bench for sisc_exec_core: a vector table for the ALU/control
// cases, hand sequences for reset-in-WRITEBACK and HLT, then random
// instructions checked against an arithmetic reference model.
module tb_sisc_exec_core;

    logic clk;
    logic rst_f;
    int   pass_cnt;
    int   total_cnt;

    sisc_exec_if #(.WIDTH(32)) bus ();

    sisc_exec_core #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [3:0]  opc;
        logic [3:0]  mm;
        logic [15:0] imm;
        logic [31:0] rsa;
        logic [31:0] rsb;
        logic [31:0] mem;
        logic [31:0] exp_res;
        logic [3:0]  exp_st;
        bit          chk_st;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {halted, alu_op, wb_sel, rf_we, stat_en}
    function automatic logic [5:0] ctrl_now();
        return {bus.halted, bus.alu_op, bus.wb_sel, bus.rf_we, bus.stat_en};
    endfunction

    function automatic logic [1:0] model_aop(input logic [3:0] opc, input logic [3:0] mm);
        if (opc == 4'd8 && mm[3]) return 2'b01;
        if (opc == 4'd1 || opc == 4'd2) return 2'b10;
        return 2'b00;
    endfunction

    // Reference ALU from plain integer arithmetic.
    task automatic model_alu(input logic [3:0] funct, input logic [1:0] aop, input logic [15:0] imm,
                             input logic [31:0] a, input logic [31:0] rb,
                             output logic [31:0] res, output logic [3:0] st);
        int          simm;
        logic [31:0] b;
        longint      ures;
        longint      sres;
        bit          c;
        bit          v;
        simm = $signed(imm);
        b    = aop[0] ? 32'(simm) : rb;
        c    = 1'b0;
        v    = 1'b0;
        res  = 32'h0;
        if (aop[1]) begin
            res = 32'(longint'(a) + longint'(simm));
            st  = 4'b0000;
        end else begin
            case (funct)
                4'd1: begin
                    ures = longint'(a) + longint'(b);
                    sres = longint'($signed(a)) + longint'($signed(b));
                    res  = 32'(ures);
                    c    = ures > 64'sd4294967295;
                    v    = sres > 64'sd2147483647 || sres < -64'sd2147483648;
                end
                4'd2: begin
                    sres = longint'($signed(a)) - longint'($signed(b));
                    res  = 32'(longint'(a) - longint'(b));
                    c    = a < b;
                    v    = sres > 64'sd2147483647 || sres < -64'sd2147483648;
                end
                4'd3: res = ~a;
                4'd4: res = a | b;
                4'd5: res = a & b;
                4'd6: res = a ^ b;
                4'd7: res = 32'(longint'(a) * (64'sd1 << b[4:0]));
                4'd8: res = 32'(longint'(a) / (64'sd1 << b[4:0]));
                default: res = 32'h0;
            endcase
            st = {c, v, res[31], res == 32'h0};
        end
    endtask

    // Runs one instruction from FETCH (entered just before the call) back to the next FETCH.
    task automatic exec_instr(input string tag, input logic [3:0] opc, input logic [3:0] mm,
                              input logic [15:0] imm, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] mem, input logic [31:0] exp_res,
                              input logic [3:0] exp_st, input bit chk_st);
        logic [1:0] aop;
        bit         alu;
        bit         lod;
        logic [5:0] exp_ctrl;
        bus.instruction = {opc, mm, 8'h00, imm};
        bus.rsa         = a;
        bus.rsb         = b;
        bus.mem_data    = mem;
        bus.stat_in     = 4'($urandom_range(0, 15));
        aop = model_aop(opc, mm);
        alu = (opc == 4'd8);
        lod = (opc == 4'd1);
        for (int ph = 0; ph < 5; ph++) begin
            @(negedge clk);
            exp_ctrl = 6'b000000;
            if (ph >= 2) exp_ctrl[4:3] = aop;
            if (ph == 2) exp_ctrl[0] = alu;
            if (ph == 4) begin
                exp_ctrl[1] = alu || lod;
                exp_ctrl[2] = lod;
            end
            check($sformatf("%s ctrl ph%0d", tag, ph), 64'(ctrl_now()), 64'(exp_ctrl));
            if (ph >= 2) check($sformatf("%s result ph%0d", tag, ph), 64'(bus.alu_result), 64'(exp_res));
            if (ph == 2 && chk_st) check({tag, " stat"}, 64'(bus.stat_out), 64'(exp_st));
            if (ph == 4) check({tag, " wdata"}, 64'(bus.write_data), lod ? 64'(mem) : 64'(exp_res));
            @(posedge clk);
        end
        #1;
    endtask

    // Holds reset across two edges, releases it mid-cycle and moves to the first FETCH.
    task automatic reset_to_fetch();
        rst_f = 1'b0;
        #1;
        check("reset ctrl", 64'(ctrl_now()), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset held ctrl", 64'(ctrl_now()), 64'h0);
        rst_f = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  s;
        logic [3:0]  opc;
        logic [3:0]  mm;
        logic [15:0] imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  opc_pool [7];

        pass_cnt  = 0;
        total_cnt = 0;
        rst_f     = 1'b1;
        bus.instruction = 32'h0;
        bus.rsa = 32'h0;
        bus.rsb = 32'h0;
        bus.mem_data = 32'h0;
        bus.stat_in = 4'h0;

        // imm[3:0] doubles as funct, so immediate-mode vectors pick imm with the wanted low nibble.
        vecs[0]  = '{"add",       4'd8, 4'd0, 16'h0001, 32'd5,        32'd7,        32'h0,        32'd12,       4'b0000, 1'b1};
        vecs[1]  = '{"add_wrap",  4'd8, 4'd0, 16'h0001, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        4'b1001, 1'b1};
        vecs[2]  = '{"add_ovf",   4'd8, 4'd0, 16'h0001, 32'h7FFFFFFF, 32'd1,        32'h0,        32'h80000000, 4'b0110, 1'b1};
        vecs[3]  = '{"sub_neg",   4'd8, 4'd0, 16'h0002, 32'd3,        32'd5,        32'h0,        32'hFFFFFFFE, 4'b1010, 1'b1};
        vecs[4]  = '{"add_imm",   4'd8, 4'd8, 16'hFFF1, 32'h0000000F, 32'h12345678, 32'h0,        32'h0,        4'b1001, 1'b1};
        vecs[5]  = '{"not",       4'd8, 4'd0, 16'h0003, 32'h0F0F0F0F, 32'h0,        32'h0,        32'hF0F0F0F0, 4'b0010, 1'b1};
        vecs[6]  = '{"or",        4'd8, 4'd0, 16'h0004, 32'h000000F0, 32'h0000000F, 32'h0,        32'h000000FF, 4'b0000, 1'b1};
        vecs[7]  = '{"and",       4'd8, 4'd0, 16'h0005, 32'h000000F0, 32'h0000000F, 32'h0,        32'h0,        4'b0001, 1'b1};
        vecs[8]  = '{"xor",       4'd8, 4'd0, 16'h0006, 32'hAAAA5555, 32'hFFFF0000, 32'h0,        32'h55555555, 4'b0000, 1'b1};
        vecs[9]  = '{"shl31",     4'd8, 4'd0, 16'h0007, 32'd1,        32'd31,       32'h0,        32'h80000000, 4'b0010, 1'b1};
        vecs[10] = '{"shr_mask",  4'd8, 4'd0, 16'h0008, 32'h80000000, 32'h24,       32'h0,        32'h08000000, 4'b0000, 1'b1};
        vecs[11] = '{"funct9",    4'd8, 4'd0, 16'h0009, 32'h1234,     32'h5678,     32'h0,        32'h0,        4'b0001, 1'b1};
        vecs[12] = '{"sub_zero",  4'd8, 4'd0, 16'h0002, 32'd5,        32'd5,        32'h0,        32'h0,        4'b0001, 1'b1};
        vecs[13] = '{"sub_ovf",   4'd8, 4'd0, 16'h0002, 32'h80000000, 32'd1,        32'h0,        32'h7FFFFFFF, 4'b0100, 1'b1};
        vecs[14] = '{"lod",       4'd1, 4'd0, 16'h0010, 32'h100,      32'h0,        32'hA5A5A5A5, 32'h110,      4'b0000, 1'b0};
        vecs[15] = '{"str",       4'd2, 4'd0, 16'hFFFC, 32'h100,      32'h0,        32'h5A5A5A5A, 32'hFC,       4'b0000, 1'b0};
        vecs[16] = '{"noop",      4'd0, 4'd0, 16'h0001, 32'd2,        32'd3,        32'h0,        32'd5,        4'b0000, 1'b0};
        vecs[17] = '{"opc5_noop", 4'd5, 4'd8, 16'h0004, 32'hF0,       32'h0F,       32'h0,        32'hFF,       4'b0000, 1'b0};

        reset_to_fetch();

        for (int i = 0; i < 18; i++) begin
            exec_instr(vecs[i].name, vecs[i].opc, vecs[i].mm, vecs[i].imm, vecs[i].rsa,
                       vecs[i].rsb, vecs[i].mem, vecs[i].exp_res, vecs[i].exp_st, vecs[i].chk_st);
        end

        // Reset in WRITEBACK of an ADD: write enable drops at once, then a clean restart.
        bus.instruction = {4'd8, 4'd0, 8'h00, 16'h0001};
        bus.rsa = 32'd5;
        bus.rsb = 32'd7;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("wb before reset rf_we", 64'(bus.rf_we), 64'd1);
        rst_f = 1'b0;
        #1;
        check("mid-wb reset ctrl", 64'(ctrl_now()), 64'h0);
        @(posedge clk);
        @(negedge clk);
        check("mid-wb reset held ctrl", 64'(ctrl_now()), 64'h0);
        rst_f = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exec_instr("post_reset_add", 4'd8, 4'd0, 16'h0001, 32'd5, 32'd7, 32'h0, 32'd12, 4'b0000, 1'b1);

        // HLT: halted latches in the HALT state, no enables, only reset leaves it.
        bus.instruction = {4'd15, 4'd8, 8'h00, 16'h0001};
        @(negedge clk);
        check("hlt fetch ctrl", 64'(ctrl_now()), 64'h0);
        @(posedge clk);
        @(negedge clk);
        check("hlt decode ctrl", 64'(ctrl_now()), 64'h0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("halt ctrl c%0d", i), 64'(ctrl_now()), 64'b100000);
        end
        reset_to_fetch();
        exec_instr("post_halt_sub", 4'd8, 4'd0, 16'h0002, 32'd10, 32'd4, 32'h0, 32'd6, 4'b0000, 1'b1);

        // Random instructions against the reference model.
        opc_pool = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd8, 4'd8, 4'd11};
        for (int i = 0; i < 60; i++) begin
            opc = opc_pool[$urandom_range(0, 6)];
            mm  = 4'($urandom_range(0, 15));
            imm = 16'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF + 32'($urandom_range(0, 2)) : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            model_alu(imm[3:0], model_aop(opc, mm), imm, a, b, r, s);
            exec_instr($sformatf("rand%0d", i), opc, mm, imm, a, b, $urandom, r, s, opc == 4'd8);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
